// File: rtl/game_countdown_timer_pkg.sv
// Shared definitions for the round countdown timer: state encoding and
// the seven-segment blank pattern.
package game_countdown_timer_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUNNING = 2'd1,
      PAUSED  = 2'd2,
      EXPIRED = 2'd3
   } timer_state_e;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/game_countdown_timer_bcd_to_7seg.sv
// Registered BCD to active-low seven-segment decoder (bit 0 = seg a, bit 6 = seg g).
// Non-BCD codes blank the digit.
module bcd_to_7seg
   import game_countdown_timer_pkg::*;
#(
   parameter logic [3:0] RESET_BCD = 4'd0
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   function automatic logic [6:0] decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // Segment register; the reset pattern matches the digit the timer reloads to.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         seg <= decode(RESET_BCD);
      end else begin
         seg <= decode(bcd);
      end
   end

endmodule

// File: rtl/game_countdown_timer.sv
// Two-digit BCD round countdown: start/pause/expiry FSM, tick edge detect,
// low-time warning and registered seven-segment outputs.
module game_countdown_timer
   import game_countdown_timer_pkg::*;
#(
   parameter int START_SECONDS = 60,
   parameter int WARN_SECONDS  = 10
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       tick_in,
   input  logic       start,
   input  logic       pause,
   output logic       tick_enable,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic [6:0] HEX1,
   output logic [6:0] HEX0,
   output logic       running,
   output logic       time_up,
   output logic       warning
);

   if (START_SECONDS < 1 || START_SECONDS > 99) begin : g_bad_start
      $error("game_countdown_timer: START_SECONDS must be within 1..99");
   end
   if (WARN_SECONDS < 0 || WARN_SECONDS > 99) begin : g_bad_warn
      $error("game_countdown_timer: WARN_SECONDS must be within 0..99");
   end

   localparam logic [3:0] START_TENS = 4'(START_SECONDS / 10);
   localparam logic [3:0] START_ONES = 4'(START_SECONDS % 10);
   localparam logic [3:0] WARN_TENS  = 4'(WARN_SECONDS / 10);
   localparam logic [3:0] WARN_ONES  = 4'(WARN_SECONDS % 10);

   timer_state_e state_r, next_state_s;
   logic [3:0]   next_tens_s, next_ones_s;
   logic         tick_q, tick_edge_s;
   logic         next_warning_s;

   assign tick_edge_s = tick_in & ~tick_q;
   assign tick_enable = running;

   // Next state and next digit value; start outranks pause, pause outranks a tick.
   always_comb begin
      next_state_s = state_r;
      next_tens_s  = tens;
      next_ones_s  = ones;
      case (state_r)
         IDLE: begin
            if (start) begin
               next_state_s = RUNNING;
               next_tens_s  = START_TENS;
               next_ones_s  = START_ONES;
            end else begin
               next_state_s = IDLE;
            end
         end
         RUNNING: begin
            if (start) begin
               next_tens_s = START_TENS;
               next_ones_s = START_ONES;
            end else if (pause) begin
               next_state_s = PAUSED;
            end else if (tick_edge_s) begin
               if (ones != 4'd0) begin
                  next_ones_s = ones - 4'd1;
                  if (tens == 4'd0 && ones == 4'd1) begin
                     next_state_s = EXPIRED;
                  end else begin
                     next_state_s = RUNNING;
                  end
               end else begin
                  next_ones_s = 4'd9;
                  next_tens_s = tens - 4'd1;
               end
            end else begin
               next_state_s = RUNNING;
            end
         end
         PAUSED: begin
            if (start) begin
               next_state_s = RUNNING;
               next_tens_s  = START_TENS;
               next_ones_s  = START_ONES;
            end else if (pause) begin
               next_state_s = RUNNING;
            end else begin
               next_state_s = PAUSED;
            end
         end
         EXPIRED: begin
            if (start) begin
               next_state_s = RUNNING;
               next_tens_s  = START_TENS;
               next_ones_s  = START_ONES;
            end else begin
               next_state_s = EXPIRED;
            end
         end
         default: begin
            next_state_s = IDLE;
            next_tens_s  = START_TENS;
            next_ones_s  = START_ONES;
         end
      endcase
   end

   // Warning compares the next value digit-wise against the BCD threshold.
   always_comb begin
      if ((next_state_s == RUNNING || next_state_s == PAUSED) &&
          ((next_tens_s < WARN_TENS) ||
           (next_tens_s == WARN_TENS && next_ones_s <= WARN_ONES))) begin
         next_warning_s = 1'b1;
      end else begin
         next_warning_s = 1'b0;
      end
   end

   // State, digits, flags and the tick history register.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_r <= IDLE;
         tens    <= START_TENS;
         ones    <= START_ONES;
         tick_q  <= 1'b0;
         running <= 1'b0;
         time_up <= 1'b0;
         warning <= 1'b0;
      end else begin
         state_r <= next_state_s;
         tens    <= next_tens_s;
         ones    <= next_ones_s;
         tick_q  <= tick_in;
         running <= (next_state_s == RUNNING);
         time_up <= (next_state_s == EXPIRED);
         warning <= next_warning_s;
      end
   end

   bcd_to_7seg #(.RESET_BCD(START_TENS)) u_seg_tens (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .bcd      (next_tens_s),
      .seg      (HEX1)
   );

   bcd_to_7seg #(.RESET_BCD(START_ONES)) u_seg_ones (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .bcd      (next_ones_s),
      .seg      (HEX0)
   );

endmodule

// File: tb/tb_game_countdown_timer.sv
// Scoreboard bench: stimulus pushes expected outputs from a seconds-level model,
// a monitor pops and compares after every clock edge.
module tb_game_countdown_timer;

   localparam int START = 12;
   localparam int WARN  = 10;

   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

   logic       CLOCK_50 = 1'b0;
   logic       reset    = 1'b1;
   logic       tick_in  = 1'b0;
   logic       start    = 1'b0;
   logic       pause    = 1'b0;
   logic       tick_enable, running, time_up, warning;
   logic [3:0] tens, ones;
   logic [6:0] HEX1, HEX0;

   typedef logic [25:0] obs_t;
   obs_t exp_q[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   int rem       = START;
   int mode      = M_IDLE;
   bit prev_tick = 1'b0;

   game_countdown_timer #(.START_SECONDS(START), .WARN_SECONDS(WARN)) dut (
      .CLOCK_50    (CLOCK_50),
      .reset       (reset),
      .tick_in     (tick_in),
      .start       (start),
      .pause       (pause),
      .tick_enable (tick_enable),
      .tens        (tens),
      .ones        (ones),
      .HEX1        (HEX1),
      .HEX0        (HEX0),
      .running     (running),
      .time_up     (time_up),
      .warning     (warning)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   function automatic logic [6:0] seg(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic obs_t expected();
      logic run, up, warn;
      run  = (mode == M_RUN);
      up   = (mode == M_EXP);
      warn = (mode == M_RUN || mode == M_PAUSE) && (rem <= WARN);
      return {4'(rem / 10), 4'(rem % 10), seg(rem / 10), seg(rem % 10), run, up, warn, run};
   endfunction

   // One clock of stimulus: drive inputs, advance the model, queue the expectation.
   task automatic step(input bit r, input bit s, input bit p, input bit t);
      bit edge_seen;
      @(negedge CLOCK_50);
      reset = r; start = s; pause = p; tick_in = t;
      edge_seen = t && !prev_tick;
      prev_tick = r ? 1'b0 : t;
      if (r) begin
         mode = M_IDLE; rem = START;
      end else if (s) begin
         mode = M_RUN; rem = START;
      end else if (p && mode == M_RUN) begin
         mode = M_PAUSE;
      end else if (p && mode == M_PAUSE) begin
         mode = M_RUN;
      end else if (edge_seen && mode == M_RUN) begin
         rem = rem - 1;
         if (rem == 0) mode = M_EXP;
      end
      exp_q.push_back(expected());
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic tick_pulse(input int hold);
      for (int i = 0; i < hold; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
      idle(2);
   endtask

   // Monitor: compares the outputs that follow each clock edge.
   initial begin
      obs_t e, a;
      forever begin
         @(posedge CLOCK_50);
         #1;
         cyc++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {tens, ones, HEX1, HEX0, running, time_up, warning, tick_enable};
            total++;
            if (a !== e) begin
               bad++;
               $display("FAIL outputs cyc=%0d got tens/ones/hex1/hex0/run/up/warn/en=%h/%h/%b/%b/%b%b%b%b want %h/%h/%b/%b/%b%b%b%b",
                        cyc, a[25:22], a[21:18], a[17:11], a[10:4], a[3], a[2], a[1], a[0],
                        e[25:22], e[21:18], e[17:11], e[10:4], e[3], e[2], e[1], e[0]);
            end
         end
      end
   end

   initial begin
      bit tlev;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
      idle(2);
      for (int i = 0; i < 10; i++) tick_pulse(2);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      idle(2);
      tick_pulse(50);
      tick_pulse(1);
      tick_pulse(3);
      tick_pulse(1);
      tick_pulse(1);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) tick_pulse(2);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      tick_pulse(1);
      tick_pulse(1);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      idle(2);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) tick_pulse(1);
      for (int i = 0; i < 3; i++) tick_pulse(2);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      idle(2);
      for (int i = 0; i < 9; i++) tick_pulse(1);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      idle(2);
      tlev = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) tlev = ~tlev;
         step(($urandom_range(0, 499) == 0), ($urandom_range(0, 149) == 0),
              ($urandom_range(0, 39) == 0), tlev);
      end
      idle(2);
      repeat (3) @(negedge CLOCK_50);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain left=%0d want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
